// File: rtl/mips_mc_pkg.sv
// Shared constants for the multicycle MIPS datapath: opcodes, funct codes,
// mux-select encodings and the internal ALU function set.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } srcb_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2,
    ALUOP_ADD2  = 2'd3
  } aluop_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_ALU2   = 2'd3
  } pcsrc_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_ZERO
  } alu_fn_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/multicycle_datapath_if.sv
// Memory bus between the multicycle datapath and its unified memory.
interface multicycle_datapath_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, synchronous reset; r0 is hardwired to zero.
module mc_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  // Reads return the stored (pre-write) value; no write-through bypass.
  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS datapath: PC/IR/MDR/A/B/ALUOut registers, register file,
// ALU with funct decode; sequenced by an external control FSM.
module multicycle_datapath
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       IorD,
  input  logic       AluSrcA,
  input  logic [1:0] ALUSrcB,
  input  logic [1:0] AlUop,
  input  logic [1:0] PCSrc,
  input  logic       IRWrite,
  input  logic       PCWrite,
  input  logic       RegDst,
  input  logic       MemtoReg,
  input  logic       RegWrite,
  input  logic       Branch,
  input  logic       MemWrite,
  output logic [5:0] OP,
  output logic       Zero,
  multicycle_datapath_if.master mem
);

  logic [31:0] pc, ir, mdr, a, b, aluout;
  logic [31:0] rd1, rd2, imm, opa, opb, alu_y, pc_next, wdata;
  logic [4:0]  waddr;
  alu_fn_e     alu_fn;

  assign mem.mem_addr  = IorD ? aluout : pc;
  assign mem.mem_wdata = b;
  assign mem.mem_we    = MemWrite;

  assign OP    = ir[31:26];
  assign imm   = sext16(ir[15:0]);
  assign waddr = RegDst ? ir[15:11] : ir[20:16];
  assign wdata = MemtoReg ? mdr : aluout;

  mc_regfile u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (ir[25:21]),
    .ra2 (ir[20:16]),
    .we  (RegWrite),
    .wa  (waddr),
    .wd  (wdata),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always_comb begin
    opa = AluSrcA ? a : pc;
    opb = b;
    case (srcb_e'(ALUSrcB))
      SRCB_REG:     opb = b;
      SRCB_FOUR:    opb = 32'd4;
      SRCB_IMM:     opb = imm;
      SRCB_IMM_SH2: opb = {imm[29:0], 2'b00};
      default:      opb = b;
    endcase
  end

  // Unknown funct codes map to a constant-zero result rather than trapping.
  always_comb begin
    alu_fn = ALU_ADD;
    case (aluop_e'(AlUop))
      ALUOP_SUB: alu_fn = ALU_SUB;
      ALUOP_FUNCT: begin
        case (ir[5:0])
          FN_ADD:  alu_fn = ALU_ADD;
          FN_SUB:  alu_fn = ALU_SUB;
          FN_AND:  alu_fn = ALU_AND;
          FN_OR:   alu_fn = ALU_OR;
          FN_SLT:  alu_fn = ALU_SLT;
          default: alu_fn = ALU_ZERO;
        endcase
      end
      default: alu_fn = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (alu_fn)
      ALU_ADD:  alu_y = opa + opb;
      ALU_SUB:  alu_y = opa - opb;
      ALU_AND:  alu_y = opa & opb;
      ALU_OR:   alu_y = opa | opb;
      ALU_SLT:  alu_y = ($signed(opa) < $signed(opb)) ? 32'd1 : 32'd0;
      default:  alu_y = '0;
    endcase
  end

  assign Zero = (alu_y == '0);

  always_comb begin
    pc_next = alu_y;
    case (pcsrc_e'(PCSrc))
      PCSRC_ALUOUT: pc_next = aluout;
      PCSRC_JUMP:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      default:      pc_next = alu_y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
    end else begin
      if (PCWrite | (Branch & Zero)) pc <= pc_next;
      if (IRWrite) ir <= mem.mem_rdata;
      mdr    <= mem.mem_rdata;
      a      <= rd1;
      b      <= rd2;
      aluout <= alu_y;
    end
  end

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have control inputs, all 1-bit unless stated: IorD, AluSrcA, ALUSrcB[1:0], AlUop[1:0], PCSrc[1:0], IRWrite, PCWrite, RegDst, MemtoReg, RegWrite, Branch, MemWrite.
REQ-003 SHALL have: OP  out  6  opcode to the control FSM, IR[31:26]; Zero  out  1  ALU result equals 0.
REQ-004 SHALL have: mem_addr  out  32  memory byte address; mem_wdata  out  32  store data; mem_we  out  1  store strobe; mem_rdata  in  32  combinational read data for mem_addr.
REQ-005 SHALL have parameter: RESET_PC, default 32'h0, PC value after reset.

Function
REQ-006 SHALL hold architectural registers PC, IR, MDR, A, B and ALUOut, each 32 bits, plus a 32x32 register file.
REQ-007 SHALL drive mem_addr = IorD ? ALUOut : PC, mem_wdata = B, and mem_we = MemWrite, all combinationally.
REQ-008 SHALL load IR <= mem_rdata on clk only when IRWrite=1, and load MDR <= mem_rdata on every clk.
REQ-009 SHALL load A <= RF[IR[25:21]], B <= RF[IR[20:16]] and ALUOut <= ALU result on every clk.
REQ-010 SHALL select ALU operand A as PC when AluSrcA=0 and as register A when AluSrcA=1.
REQ-011 SHALL select ALU operand B by ALUSrcB: 0 = B; 1 = 32'd4; 2 = sign-extended IR[15:0]; 3 = sign-extended IR[15:0] << 2.
REQ-012 SHALL select the ALU operation by AlUop: 0 = add; 1 = subtract; 2 = decode IR[5:0]; 3 = add.
REQ-013 SHALL decode IR[5:0] when AlUop=2 as: 32 = add, 34 = sub, 36 = and, 37 = or, 42 = signed slt producing 1 or 0; any other funct SHALL produce result 0.
REQ-014 SHALL perform add and sub modulo 2^32, with no overflow flag and no exception.
REQ-015 SHALL drive Zero = (ALU result == 0), combinationally.
REQ-016 SHALL select the next PC by PCSrc: 0 = ALU result; 1 = ALUOut; 2 = {PC[31:28], IR[25:0], 2'b00}; 3 = ALU result.
REQ-017 SHALL load PC on clk when PCWrite | (Branch & Zero) is 1, and otherwise hold PC.
REQ-018 SHALL write the register file on clk when RegWrite=1, to address RegDst ? IR[15:11] : IR[20:16], with data MemtoReg ? MDR : ALUOut.
REQ-019 SHALL keep register 0 reading 0 and ignore writes to it.
REQ-020 SHALL return the pre-write value when a register is written and read in the same cycle; there is no bypass, and A/B see the new value one cycle later.
REQ-021 SHALL drive OP combinationally from the current IR, so a new opcode is visible in the cycle after the IRWrite edge.
REQ-022 SHALL treat a simultaneous PCWrite and Branch as a single PC load using the PCSrc selection.

Reset
REQ-023 SHALL, on rst=1 at clk, set PC to RESET_PC and set IR, MDR, A, B, ALUOut and all 32 registers to 0.
REQ-024 SHALL give rst priority over every write enable, including mid-instruction, so no PC, IR or register-file write occurs in the reset cycle.
REQ-025 SHALL, after reset, present OP = 0, Zero = 1 when the ALU inputs are zero, and mem_we = MemWrite.

Structure
REQ-026 SHALL take the opcode constants (LW 35, SW 43, RTYPE 0, BEQ 4, ADDI 8, J 2), the funct codes, and the ALUSrcB/PCSrc/AlUop encodings from a shared package, mips_mc_pkg.
REQ-027 SHALL implement the register file as a single sub-module, mc_regfile, with 2 asynchronous read ports and 1 synchronous write port with synchronous reset.
REQ-028 SHALL keep the ALU and its funct decoder inside the top module.

Verification
REQ-029 Fetch: mem_rdata = 32'h8C22_0004 (lw) at PC=0 with IRWrite=1, PCWrite=1, AluSrcA=0, ALUSrcB=1, PCSrc=0 -> PC=4, and OP=35 on the next cycle.
REQ-030 lw path: R1=100, then address, memory and write-back cycles with mem_rdata=32'hDEAD_BEEF -> mem_addr=104 while IorD=1, and R2=32'hDEAD_BEEF after RegWrite with MemtoReg=1.
REQ-031 R-type: R1=5, R2=7, funct 34 -> ALUOut=32'hFFFF_FFFE; funct 42 -> 1; funct 63 -> 0; add of 32'hFFFF_FFFF and 1 -> 0 with Zero=1.
REQ-032 beq: R1=R2=9, PC=8, imm=3 -> with Branch=1, AluSrcA=1, ALUSrcB=0, AlUop=1, PCSrc=1, PC = ALUOut = 20; with R1 != R2, PC stays 8.
REQ-033 j: IR=32'h0800_0010 with PCSrc=2, PCWrite=1 -> PC=32'h0000_0040; sw: MemWrite=1 and IorD=1 -> mem_we=1 and mem_wdata=B.
REQ-034 Reset mid-instruction plus r0: assert rst with RegWrite=1 and PCWrite=1 -> PC=RESET_PC and all registers 0; a write of 32'h1234 to r0 -> r0 still reads 0.
